// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM state type, round constants, S-boxes and GF(2^8) arithmetic.
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {IDLE, KEY_EXP, DEC, DONE} aesStateT;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 = product of a^(2^i) for i = 1..7; maps 0 to 0.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h01;
    p   = a;
    for (int i = 1; i < 8; i++) begin
      p   = gfMul(p, p);
      acc = gfMul(acc, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gfInv(b);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] b);
    return gfInv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] rotWord(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Ciphertext/key request channel and plaintext response channel of the iterative AES decryptor.
interface aes_decrypt_iter_if;

  logic                        in_valid;
  logic                        in_ready;
  logic [aes_pkg::BLOCK_W-1:0] ciphertext;
  logic [aes_pkg::BLOCK_W-1:0] key;
  logic                        out_valid;
  logic                        out_ready;
  logic [aes_pkg::BLOCK_W-1:0] plaintext;
  logic                        busy;

  modport master (
    output in_valid, ciphertext, key, out_ready,
    input  in_ready, out_valid, plaintext, busy
  );

  modport slave (
    input  in_valid, ciphertext, key, out_ready,
    output in_ready, out_valid, plaintext, busy
  );

endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] stateIn,
  input  logic [BLOCK_W-1:0] roundKey,
  input  logic               lastRound,
  output logic [BLOCK_W-1:0] stateOut
);

  logic [BLOCK_W-1:0] keyed;
  logic [BLOCK_W-1:0] mixed;

  // Byte (row r, column c) sits at index 4c+r; row r is rotated right by r columns.
  always_comb begin
    keyed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        keyed[127-8*(4*c+r) -: 8] = invSbox(stateIn[127-8*(4*((c+4-r)%4)+r) -: 8])
                                    ^ roundKey[127-8*(4*c+r) -: 8];
      end
    end
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = keyed[127-32*c -: 8];
      a1 = keyed[119-32*c -: 8];
      a2 = keyed[111-32*c -: 8];
      a3 = keyed[103-32*c -: 8];
      mixed[127-32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
      mixed[119-32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
      mixed[111-32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
      mixed[103-32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
    end
  end

  assign stateOut = lastRound ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: forward key expansion to k10 (optionally cached), then ten inverse rounds.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int CACHE_KEY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_decrypt_iter_if.slave bus
);

  aesStateT           fsm;
  logic [3:0]         rnd;
  logic [BLOCK_W-1:0] keyReg, stateReg, ctReg, ptReg;
  logic [BLOCK_W-1:0] cacheKey, cacheK10;
  logic               cacheValid, outValid, inReady, busyR;
  logic [BLOCK_W-1:0] kNext, kPrev, roundOut;
  logic               cacheHit, lastRound;

  function automatic logic [BLOCK_W-1:0] keyStep(input logic [BLOCK_W-1:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ subWord(rotWord(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [BLOCK_W-1:0] keyUnstep(input logic [BLOCK_W-1:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ subWord(rotWord(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // During KEY_EXP rnd is the round being produced; during DEC it is r+1 for the key being recovered.
  assign kNext     = keyStep(keyReg, rcon(rnd));
  assign kPrev     = keyUnstep(keyReg, rcon(rnd));
  assign lastRound = (rnd == 4'd1);
  assign cacheHit  = (CACHE_KEY != 0) && cacheValid && (bus.key == cacheKey);

  aes_inv_round uInvRound (
    .stateIn  (stateReg),
    .roundKey (kPrev),
    .lastRound(lastRound),
    .stateOut (roundOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      rnd        <= 4'd0;
      keyReg     <= '0;
      stateReg   <= '0;
      ctReg      <= '0;
      ptReg      <= '0;
      cacheKey   <= '0;
      cacheK10   <= '0;
      cacheValid <= 1'b0;
      outValid   <= 1'b0;
      inReady    <= 1'b1;
      busyR      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            ctReg   <= bus.ciphertext;
            inReady <= 1'b0;
            busyR   <= 1'b1;
            if (cacheHit) begin
              stateReg <= bus.ciphertext ^ cacheK10;
              keyReg   <= cacheK10;
              rnd      <= 4'd10;
              fsm      <= DEC;
            end else begin
              // The cipher key is latched into the cache now but only trusted once k10 lands.
              cacheKey   <= bus.key;
              cacheValid <= 1'b0;
              keyReg     <= bus.key;
              rnd        <= 4'd1;
              fsm        <= KEY_EXP;
            end
          end
        end
        KEY_EXP: begin
          keyReg <= kNext;
          if (rnd == 4'd10) begin
            stateReg   <= ctReg ^ kNext;
            cacheK10   <= kNext;
            cacheValid <= 1'b1;
            fsm        <= DEC;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DEC: begin
          stateReg <= roundOut;
          keyReg   <= kPrev;
          if (lastRound) begin
            ptReg    <= roundOut;
            outValid <= 1'b1;
            rnd      <= 4'd0;
            fsm      <= DONE;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            busyR    <= 1'b0;
            fsm      <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.plaintext = ptReg;
  assign bus.busy      = busyR;

endmodule

// File: doc/aes_decrypt_iter.md
AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
REQ-001 Parameter: CACHE_KEY, 1, when 1 the block retains the last expanded key and skips expansion when the new key matches it.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  ciphertext/key offer.
REQ-005 in_ready  output  1  block can accept; high only in IDLE.
REQ-006 ciphertext  input  128  AES-128 block, byte 0 at [127:120].
REQ-007 key  input  128  AES-128 cipher key (round-0 key), byte 0 at [127:120].
REQ-008 out_valid  output  1  plaintext valid.
REQ-009 out_ready  input  1  consumer accepts plaintext.
REQ-010 plaintext  output  128  decrypted block, byte 0 at [127:120].
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, KEY_EXP, DEC and DONE.
REQ-013 An accept SHALL occur on an edge where in_valid and in_ready are both high; ciphertext and key are captured on that edge.
REQ-014 On accept, when CACHE_KEY=0, the cache is invalid, or key differs from the cached key, the FSM SHALL go to KEY_EXP with the key register loaded with key and the round counter at 1.
REQ-015 KEY_EXP SHALL run 10 cycles; each cycle it steps the key register forward one round (RotWord, SubWord, Rcon[r]) to produce k1..k10.
REQ-016 On the 10th KEY_EXP edge, the state register SHALL load ciphertext XOR k10, the cache SHALL store key and k10 and become valid, and the FSM SHALL go to DEC.
REQ-017 On accept with a cache hit, the state register SHALL load ciphertext XOR cached k10, the key register SHALL load cached k10, and the FSM SHALL go directly to DEC.
REQ-018 DEC SHALL run 10 cycles for r = 9 down to 0. Each cycle:
- derive k_r from k_{r+1} combinationally by the inverse schedule: w3=w3'^w2', w2=w2'^w1', w1=w1'^w0', w0=w0'^SubWord(RotWord(w3))^Rcon[r+1];
- state <= InvShiftRows, InvSubBytes, XOR k_r, then InvMixColumns when r>0 only;
- key register <= k_r.
REQ-019 On the last DEC edge (r=0), plaintext SHALL register the result, out_valid SHALL go high, and the FSM SHALL go to DONE.
REQ-020 Latency from the accept edge to out_valid high SHALL be 20 cycles on a cache miss and 10 cycles on a cache hit.
REQ-021 In DONE, plaintext and out_valid SHALL hold stable until out_ready is high.
REQ-022 On the edge where out_valid and out_ready are both high, the FSM SHALL go to IDLE and out_valid SHALL fall; in_ready rises the following cycle (no same-cycle re-accept).
REQ-023 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-024 Rcon SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-025 InvMixColumns SHALL use GF(2^8) with polynomial 0x11b and coefficients 0e,0b,0d,09.

Reset
REQ-026 rst_n low SHALL asynchronously force: FSM to IDLE; out_valid=0; busy=0; in_ready=1 after release; plaintext, state and key registers=0; round counter=0; cache valid=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no partial output, and the next accept SHALL be treated as a cache miss.

Structure
REQ-028 A shared package aes_pkg SHALL hold the FSM state enum, the Rcon table, the forward and inverse S-box functions, and the xtime/GF-multiply functions.
REQ-029 The combinational inverse round (InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns with a last-round select) SHALL be sub-module aes_inv_round.
REQ-030 The sequencing, key schedule stepping and cache SHALL live in aes_decrypt_iter.

Verification
REQ-031 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, out_valid 20 cycles after accept.
REQ-032 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734; a second ct with the same key -> out_valid at 10 cycles (cache hit).
REQ-033 Hold out_ready low for 7 cycles in DONE -> plaintext stable, in_ready low; out_ready high -> IDLE the next cycle.
REQ-034 Pulse rst_n low during DEC round 5 -> out_valid never asserts, in_ready high after release; the same key retried -> 20-cycle latency.
REQ-035 Alternate between the C.1 and B keys back to back with in_valid held high -> every result correct and every latency 20 cycles.
